k16_mem_arbiter: RTL and testbench

//   Shares the single synchronous RAM port between the K16 CPU and the VGA character/framebuffer fetcher.

---
 rtl/k16_mem_arbiter.sv | 97 +++++++++
 tb/tb_k16_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/k16_mem_arbiter.sv
// Single-port RAM arbiter between the K16 CPU and the VGA fetcher.
// Video has priority; a wait limiter forces a CPU slot after CPU_MAX_WAIT denials.
//
// owner state | meaning
// ------------+-----------------------------------------------
// OWN_NONE    | no access issued last cycle, nothing returns
// OWN_CPU     | CPU access issued last cycle, cpu_ready now
// OWN_VID     | video read issued last cycle, vid_rvalid now
module k16_mem_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int CPU_MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_gnt,
   output logic              vid_rvalid,
   output logic [DATA_W-1:0] vid_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_VID  = 2'd2
   } owner_t;

   localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

   owner_t     owner_q, owner_d;
   logic       cpu_wr_q, cpu_wr_d;
   logic [3:0] wait_q, wait_d;
   logic       cpu_elig, gnt_cpu, gnt_vid;

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q  <= OWN_NONE;
         cpu_wr_q <= 1'b0;
         wait_q   <= 4'd0;
      end else begin
         owner_q  <= owner_d;
         cpu_wr_q <= cpu_wr_d;
         wait_q   <= wait_d;
      end
   end

   always_comb begin
      cpu_ready  = (owner_q == OWN_CPU);
      vid_rvalid = (owner_q == OWN_VID);
      cpu_rdata  = (cpu_ready && !cpu_wr_q) ? mem_rdata : '0;
      vid_rdata  = vid_rvalid ? mem_rdata : '0;

      // CPU sits out its own return cycle so a held cpu_req is not re-issued early
      cpu_elig = cpu_req & ~cpu_ready;
      gnt_cpu  = ~reset & cpu_elig & (~vid_req | (wait_q == MAX_WAIT));
      gnt_vid  = ~reset & ~gnt_cpu & vid_req;

      vid_gnt   = gnt_vid;
      mem_write = gnt_cpu & cpu_write;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt_cpu) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (gnt_vid) begin
         mem_addr = vid_addr;
      end

      owner_d  = OWN_NONE;
      cpu_wr_d = 1'b0;
      if (gnt_cpu) begin
         owner_d  = OWN_CPU;
         cpu_wr_d = cpu_write;
      end else if (gnt_vid) begin
         owner_d = OWN_VID;
      end

      wait_d = wait_q;
      if (gnt_cpu || !cpu_req) begin
         wait_d = 4'd0;
      end else if (cpu_elig && (wait_q < MAX_WAIT)) begin
         wait_d = wait_q + 4'd1;
      end
   end

endmodule

// File: tb/tb_k16_mem_arbiter.sv
// Bench for k16_mem_arbiter: directed scenarios then randomized traffic,
// checked against a transaction-level model with its own shadow memory.
module tb_k16_mem_arbiter;

   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_write;
   logic [15:0] cpu_addr, cpu_wdata;
   logic        cpu_ready;
   logic [15:0] cpu_rdata;
   logic        vid_req;
   logic [15:0] vid_addr;
   logic        vid_gnt, vid_rvalid;
   logic [15:0] vid_rdata;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_write;
   logic [15:0] mem_rdata;

   k16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .CPU_MAX_WAIT(MAXW)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
      .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // RAM environment (single writer: the stimulus process) and model shadow memory
   logic [15:0] ram    [0:65535];
   logic [15:0] shadow [0:65535];
   logic        env_we;
   logic [15:0] env_a, env_d;

   int checks = 0;
   int failures = 0;

   // model: pending return kind (0 none, 1 cpu read, 2 cpu write, 3 video) and denial count
   int          m_ret;
   logic [15:0] m_data;
   int          m_den;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic cr, input logic cw, input logic [15:0] ca,
                       input logic [15:0] cd, input logic vr, input logic [15:0] va);
      logic cpu_ret, elig, cpu_win, vid_win;
      logic [15:0] exp_addr;
      @(posedge clk);
      mem_rdata = ram[env_a];
      if (env_we) ram[env_a] = env_d;
      #1;
      reset = r; cpu_req = cr; cpu_write = cw; cpu_addr = ca; cpu_wdata = cd;
      vid_req = vr; vid_addr = va;
      @(negedge clk);

      cpu_ret = (m_ret == 1) || (m_ret == 2);
      chk("cpu_ready", cpu_ready, cpu_ret);
      chk("cpu_rdata", cpu_rdata, (m_ret == 1) ? m_data : 16'h0);
      chk("vid_rvalid", vid_rvalid, m_ret == 3);
      chk("vid_rdata", vid_rdata, (m_ret == 3) ? m_data : 16'h0);

      elig    = !r && cr && !cpu_ret;
      cpu_win = elig && (!vr || m_den >= MAXW);
      vid_win = !r && vr && !cpu_win;
      exp_addr = cpu_win ? ca : (vid_win ? va : 16'h0);
      chk("vid_gnt", vid_gnt, vid_win);
      chk("mem_write", mem_write, cpu_win && cw);
      chk("mem_addr", mem_addr, exp_addr);
      if (cpu_win) chk("mem_wdata", mem_wdata, cd);

      if (r) begin
         m_ret = 0;
         m_den = 0;
      end else begin
         if (cpu_win) begin
            m_ret  = cw ? 2 : 1;
            m_data = shadow[ca];
            if (cw) shadow[ca] = cd;
         end else if (vid_win) begin
            m_ret  = 3;
            m_data = shadow[va];
         end else begin
            m_ret = 0;
         end
         if (cpu_win || !cr) m_den = 0;
         else if (elig) m_den = (m_den + 1 > MAXW) ? MAXW : m_den + 1;
      end

      env_we = mem_write;
      env_a  = mem_addr;
      env_d  = mem_wdata;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
   endtask

   initial begin
      logic        busy, c_w, saw_ready, rst, vr;
      logic [15:0] c_a, c_d, va;
      int          wr_pulses;

      reset = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      vid_req = 1'b0; vid_addr = '0; mem_rdata = '0;
      env_we = 1'b0; env_a = '0; env_d = '0;
      m_ret = 0; m_den = 0; m_data = '0;
      for (int a = 0; a < 65536; a++) begin
         ram[a]    = 16'(a) ^ 16'h5a5a;
         shadow[a] = 16'(a) ^ 16'h5a5a;
      end
      ram[5] = 16'h7300; shadow[5] = 16'h7300;
      for (int i = 0; i < 4; i++) begin
         ram[16'h8000 + i]    = 16'hC000 + 16'(i);
         shadow[16'h8000 + i] = 16'hC000 + 16'(i);
      end

      step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
      step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
      idle();
      chk("rst_ready", cpu_ready, 1'b0);
      chk("rst_rvalid", vid_rvalid, 1'b0);

      // CPU read, no video
      step(1'b0, 1'b1, 1'b0, 16'd5, 16'h0, 1'b0, 16'h0);
      chk("t1_addr", mem_addr, 16'd5);
      step(1'b0, 1'b1, 1'b0, 16'd5, 16'h0, 1'b0, 16'h0);
      chk("t1_ready", cpu_ready, 1'b1);
      chk("t1_rdata", cpu_rdata, 16'h7300);
      chk("t1_no_regrant", mem_addr, 16'h0);
      idle();

      // back-to-back video reads
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h8000 + 16'(i));
         chk("t2_gnt", vid_gnt, 1'b1);
         if (i > 0) chk("t2_rdata", vid_rdata, 16'hC000 + 16'(i - 1));
      end
      idle();
      chk("t2_last_valid", vid_rvalid, 1'b1);
      chk("t2_last_rdata", vid_rdata, 16'hC003);

      // CPU write under continuous video: wait limiter
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 1'b1, 16'd100, 16'h1234, 1'b1, 16'h8000 + 16'(i % 4));
         if (i < 4) chk("t3_vid_gnt", vid_gnt, 1'b1);
         if (i == 4) begin
            chk("t3_vid_blocked", vid_gnt, 1'b0);
            chk("t3_mem_write", mem_write, 1'b1);
         end
         if (i == 5) chk("t3_ready", cpu_ready, 1'b1);
      end
      idle();
      chk("t3_ram", ram[100], 16'h1234);

      // simultaneous requests: video first, CPU when video drops
      step(1'b0, 1'b1, 1'b0, 16'd7, 16'h0, 1'b1, 16'h9000);
      chk("t4_vid_first", vid_gnt, 1'b1);
      step(1'b0, 1'b1, 1'b0, 16'd7, 16'h0, 1'b1, 16'h9001);
      chk("t4_vid_second", vid_gnt, 1'b1);
      step(1'b0, 1'b1, 1'b0, 16'd7, 16'h0, 1'b0, 16'h0);
      chk("t4_cpu_addr", mem_addr, 16'd7);
      step(1'b0, 1'b1, 1'b0, 16'd7, 16'h0, 1'b0, 16'h0);
      chk("t4_cpu_ready", cpu_ready, 1'b1);
      idle();

      // cpu_req held through the ready cycle: one write, re-grant only after
      wr_pulses = 0;
      step(1'b0, 1'b1, 1'b1, 16'd101, 16'hABCD, 1'b0, 16'h0);
      wr_pulses += int'(mem_write);
      step(1'b0, 1'b1, 1'b1, 16'd101, 16'hABCD, 1'b0, 16'h0);
      wr_pulses += int'(mem_write);
      chk("t5_one_write", wr_pulses, 1);
      chk("t5_ready", cpu_ready, 1'b1);
      step(1'b0, 1'b1, 1'b1, 16'd101, 16'hABCD, 1'b0, 16'h0);
      chk("t5_regrant", mem_write, 1'b1);
      idle();
      idle();
      chk("t5_ram", ram[101], 16'hABCD);

      // reset during a video return cycle with CPU denials accumulated
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 1'b1, 16'd50, 16'h5555, 1'b1, 16'h0200 + 16'(i));
      step(1'b1, 1'b1, 1'b1, 16'd50, 16'h5555, 1'b1, 16'h0203);
      chk("t6_rst_write", mem_write, 1'b0);
      chk("t6_rst_gnt", vid_gnt, 1'b0);
      step(1'b0, 1'b1, 1'b1, 16'd50, 16'h5555, 1'b1, 16'h0204);
      chk("t6_rvalid_dropped", vid_rvalid, 1'b0);
      chk("t6_ready_clear", cpu_ready, 1'b0);
      chk("t6_wait_cleared", vid_gnt, 1'b1);
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b1, 1'b1, 16'd50, 16'h5555, 1'b1, 16'h0205 + 16'(i));
      idle();

      // randomized traffic
      busy = 1'b0; saw_ready = 1'b0; c_w = 1'b0; c_a = '0; c_d = '0;
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         if (saw_ready) busy = 1'b0;
         if (busy && $urandom_range(0, 15) == 0) busy = 1'b0;
         if (rst) busy = 1'b0;
         if (!busy && !rst && $urandom_range(0, 1) == 1) begin
            busy = 1'b1;
            c_w  = 1'($urandom_range(0, 1));
            c_a  = 16'($urandom_range(0, 31));
            c_d  = 16'($urandom);
         end
         vr = ($urandom_range(0, 3) != 0);
         va = 16'($urandom_range(0, 31));
         step(rst, busy, c_w, c_a, c_d, vr, va);
         saw_ready = !rst && cpu_ready;
      end
      idle();
      idle();
      for (int a = 0; a < 32; a++) chk("ram_final", ram[a], shadow[a]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
